ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 12000, meaning clock-inhibit length in clk cycles (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2000000, meaning the maximum clk cycles between device clock falling edges before abort.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic runs in this domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port ps2_clk_in, input, 1 bit: sensed PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2_data_in, input, 1 bit: sensed PS/2 data line, asynchronous.
REQ-007 SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls the PS/2 clock line low; 0 releases it.
REQ-008 SHALL have port ps2_data_oe, output, 1 bit: 1 pulls the PS/2 data line low; 0 releases it.
REQ-009 SHALL have port tx_data, input, 8 bits: command byte to send to the keyboard.
REQ-010 SHALL have port tx_valid, input, 1 bit: command request.
REQ-011 SHALL have port tx_ready, output, 1 bit: high only in IDLE.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE; the receiver uses it to ignore bus traffic.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse on acknowledged completion.
REQ-014 SHALL have port tx_err, output, 1 bit: one-cycle pulse on timeout or missing acknowledge.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through 3-flop synchronizers; a device clock falling edge (fe) is synced stage 2 low while stage 3 high.
REQ-016 SHALL accept a byte only on a cycle with tx_valid=1 and tx_ready=1, latching tx_data and the odd-parity bit (~^tx_data).
REQ-017 SHALL ignore tx_valid while busy; the latched byte is not affected.
REQ-018 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-019 SHALL enter INHIBIT in the cycle after acceptance.
REQ-020 In INHIBIT, SHALL hold ps2_clk_oe=1 for exactly INHIBIT_CYC cycles and assert ps2_data_oe=1 (start bit) in the final INHIBIT cycle.
REQ-021 In REQ, SHALL set ps2_clk_oe=0 and keep ps2_data_oe=1, then move to SHIFT at the first fe.
REQ-022 In SHIFT, SHALL drive one frame bit per fe: bit index 0..7 LSB-first, then parity, then stop; ps2_data_oe equals the inverse of the current bit, and the stop bit sets ps2_data_oe=0.
REQ-023 SHALL use a 4-bit bit counter; SHIFT exits to ACK at the fe that drives the stop bit.
REQ-024 In ACK, at the next fe, SHALL sample synced data: 0 goes to WAIT_IDLE; 1 pulses tx_err and goes to IDLE.
REQ-025 In WAIT_IDLE, once synced clk=1 and data=1, SHALL pulse tx_done and go to IDLE.
REQ-026 SHALL reset a watchdog counter on entry to REQ and on every fe in REQ, SHIFT, ACK and WAIT_IDLE.
REQ-027 When the watchdog reaches TIMEOUT_CYC, SHALL pulse tx_err, release both lines and go to IDLE in the same cycle.
REQ-028 SHALL never pulse tx_done and tx_err in the same cycle.
REQ-029 SHALL make tx_ready, and hence acceptance of the next byte, no earlier than the cycle after tx_done or tx_err.

Reset
REQ-030 While rst=0, SHALL hold state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, busy=0, and all counters and synchronizer flops at 0.
REQ-031 tx_ready SHALL read 0 during reset and 1 from the first clk edge after rst deasserts.
REQ-032 On rst assertion mid-frame, SHALL release both lines immediately (asynchronously) and emit no done/err pulse.

Structure
REQ-033 Package ps2_pkg SHALL hold the state enum, command constants (CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF) and default INHIBIT_CYC/TIMEOUT_CYC.
REQ-034 Sub-module ps2_line_sync SHALL provide the 3-flop synchronizers plus fe detect, reusable by the keyboard receiver.

Verification
REQ-035 Send 8'hED with a device model clocking at 12.5 kHz and acking -> clk held low 12000 cycles; data bits on line 1,0,1,1,0,1,1,1; parity 1; stop 1; exactly one tx_done.
REQ-036 Send 8'hF4 -> parity bit on line 0; tx_done pulses once; tx_ready returns high the cycle after.
REQ-037 Device never clocks after REQ -> tx_err exactly TIMEOUT_CYC cycles after REQ entry; both oe=0.
REQ-038 Device clocks all 11 edges but holds data high at ACK -> tx_err, no tx_done.
REQ-039 Pulse tx_valid with 8'hFF during SHIFT bit 4 -> ignored; the frame still carries the original byte.
REQ-040 Assert rst low during SHIFT bit 3 -> both oe drop to 0 without a clk edge; no pulses; IDLE after release.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam int unsigned DEF_INHIBIT_CYC = 12000;
    localparam int unsigned DEF_TIMEOUT_CYC = 2000000;

    // Frame register holds data[7:0] plus parity at index 8; the stop bit is implicit.
    localparam int unsigned FRAME_W        = 9;
    localparam int unsigned BIT_W          = 4;
    localparam logic [3:0]  LAST_SHIFT_IDX = 4'd8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizers for the PS/2 clock and data lines plus clock falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe_c
);

    logic [2:0] clk_sr;
    logic [2:0] data_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr  <= '0;
            data_sr <= '0;
        end else begin
            clk_sr  <= {clk_sr[1:0], ps2_clk};
            data_sr <= {data_sr[1:0], ps2_data};
        end
    end

    assign clk_sync  = clk_sr[2];
    assign data_sync = data_sr[2];
    // Stage 2 already low while stage 3 still high marks a falling edge.
    assign clk_fe_c  = ~clk_sr[1] & clk_sr[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift 10 bits, check ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic clk_sync;
    logic data_sync;
    logic fe;

    ps2_line_sync u_sync (
        .clk      (clk),
        .rst_n    (rst),
        .ps2_clk  (ps2_clk_in),
        .ps2_data (ps2_data_in),
        .clk_sync (clk_sync),
        .data_sync(data_sync),
        .clk_fe_c (fe)
    );

    ps2_tx_state_e      state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_idx, bit_n, bit_inc;
    logic [FRAME_W-1:0] frame, frame_n;
    logic clk_oe_q, clk_oe_n;
    logic data_oe_q, data_oe_n;
    logic done_q, done_n;
    logic err_q, err_n;
    logic ready_q, ready_n;
    logic busy_q, busy_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            frame     <= frame_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            err_q     <= err_n;
            ready_q   <= ready_n;
            busy_q    <= busy_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        frame_n   = frame;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        bit_inc   = bit_idx + BIT_W'(1);

        case (state)
            ST_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid && ready_q) begin
                    state_n   = ST_INHIBIT;
                    cnt_n     = '0;
                    frame_n   = {odd_parity(tx_data), tx_data};
                    clk_oe_n  = 1'b1;
                    data_oe_n = (INH_LAST == '0);
                end
            end
            ST_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n   = ST_REQ;
                    cnt_n     = '0;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n     = cnt + CNT_W'(1);
                    data_oe_n = (cnt_n == INH_LAST);
                end
            end
            ST_REQ: begin
                if (fe) begin
                    state_n   = ST_SHIFT;
                    bit_n     = '0;
                    data_oe_n = ~frame[0];
                end
            end
            ST_SHIFT: begin
                if (fe) begin
                    bit_n = bit_inc;
                    if (bit_idx == LAST_SHIFT_IDX) begin
                        state_n   = ST_ACK;
                        data_oe_n = 1'b0;
                    end else begin
                        data_oe_n = ~frame[bit_inc];
                    end
                end
            end
            ST_ACK: begin
                if (fe) begin
                    if (!data_sync) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        state_n = ST_IDLE;
                        err_n   = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Watchdog between device clock edges; a normal completion wins over a coincident timeout.
        if (state inside {ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
            cnt_n = fe ? '0 : cnt + CNT_W'(1);
            if (!fe && !done_n && (cnt == TMO_LAST)) begin
                state_n   = ST_IDLE;
                err_n     = 1'b1;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
        end

        ready_n = (state_n == ST_IDLE) && !done_n && !err_n;
        busy_n  = (state_n != ST_IDLE);
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign tx_ready    = ready_q;
    assign busy        = busy_q;

endmodule
